// File: rtl/apb_cmd_queue.sv
// Purpose: buffers host write/read commands and issues them one at a time to an APB master, watching the bus for completion.
// Latency: a command pushed into an empty idle queue raises newd one cycle later; issues are at least 3 cycles apart.
// Backpressure: cmd_ready drops while DEPTH entries are queued; a transfer stalled for TIMEOUT wait cycles is aborted.
module apb_cmd_queue #(
  parameter int AW      = 3,
  parameter int DW      = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [AW-1:0]                cmd_addr,
  input  logic [DW-1:0]                cmd_data,
  output logic                         wr,
  output logic                         newd,
  output logic [AW-1:0]                ain,
  output logic [DW-1:0]                din,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pready,
  input  logic [DW-1:0]                prdata,
  output logic                         rsp_valid,
  output logic [DW-1:0]                rsp_data,
  output logic                         done,
  output logic                         timeout_err,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int EW = 1 + AW + DW;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            push, pop;
  logic            wr_nxt, newd_nxt, done_nxt, terr_nxt, rsp_valid_nxt;
  logic [AW-1:0]   ain_nxt;
  logic [DW-1:0]   din_nxt, rsp_data_nxt;

  // Acceptance depends only on occupancy, never on a pop in the same cycle.
  assign cmd_ready = (count < CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);

  // Command storage; the entry is {wr, addr, data}.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_wr, cmd_addr, cmd_data};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Transfer sequencing: issue the head, then wait for bus completion or timeout.
  always_comb begin
    state_nxt     = state;
    tcnt_nxt      = tcnt;
    wr_nxt        = wr;
    ain_nxt       = ain;
    din_nxt       = din;
    newd_nxt      = 1'b0;
    done_nxt      = 1'b0;
    terr_nxt      = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    pop           = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          {wr_nxt, ain_nxt, din_nxt} = mem[rptr];
          newd_nxt  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (psel & penable & pready) begin
          pop       = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          if (!wr) begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = prdata;
          end
        end else if (tcnt == TLAST) begin
          pop       = 1'b1;
          done_nxt  = 1'b1;
          terr_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered state and outputs; master command lines hold their value while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      tcnt        <= '0;
      wr          <= 1'b0;
      ain         <= '0;
      din         <= '0;
      newd        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      wr          <= wr_nxt;
      ain         <= ain_nxt;
      din         <= din_nxt;
      newd        <= newd_nxt;
      done        <= done_nxt;
      timeout_err <= terr_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
    end
  end

endmodule
